// File: rtl/ser_seq_pkg.sv
// Shared types and constants for the serial-window transfer sequencer.
package ser_seq_pkg;

    localparam int unsigned LEN_W = 4;
    localparam logic [LEN_W-1:0] LEN_MAX = 4'd8;

    // ba[13:12] pattern that selects the serial window
    localparam logic [1:0] WIN_SEL = 2'b01;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h1;
    localparam logic [3:0] OFF_LEN    = 4'h2;
    localparam logic [3:0] OFF_CTRL   = 4'h3;

    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_DONE  = 1;
    localparam int unsigned STAT_OVR   = 2;
    localparam int unsigned STAT_ABORT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_HOLD  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic abort;
        logic overrun;
        logic done;
        logic busy;
    } status_t;

    // LEN of 0 or above 8 means a full byte
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return ((len == '0) || (len > LEN_MAX)) ? LEN_MAX : len;
    endfunction

endpackage

// File: rtl/ser_phase_tick.sv
// Loadable phase down-counter; flags the first and last cycle of each CLK_DIV-long phase.
module ser_phase_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_tick_c,
    output logic o_first_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_TOP;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tick_c  = (r_cnt == '0);
    assign o_first_c = (r_cnt == CNT_TOP);

endmodule

// File: rtl/ser_window_seq.sv
// Bus-mapped serial transfer sequencer for the serial-select address window.
// Optional SER_LOOPBACK_EN adds CTRL.lpbk (offset 0x3) feeding sdo back into the sampler.
module ser_window_seq
    import ser_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_stb,
    input  logic [13:0]       ba,
    input  logic              br_w,
    input  logic              sser,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              scs_n,
    output logic              sclk,
    output logic              sdo,
    input  logic              sdi,
    output logic              busy,
    output logic              done_irq
);

    seq_state_e        r_state, w_state_next;
    logic              r_start;
    logic [DATA_W-1:0] r_tx, r_shift, r_rx;
    logic [LEN_W-1:0]  r_len, r_bits;
    logic              r_scs_n, r_sclk, r_sdo, r_busy;
    logic              r_done, r_ovr, r_abort;

    logic              w_hit, w_wr, w_wr_data, w_wr_len, w_wr_stat;
    logic              w_active, w_acc_data;
    logic [3:0]        w_off;
    logic              w_load, w_tick, w_first, w_shift;
    logic              w_done_set, w_abort_set;
    logic              w_scs_n_nx, w_sclk_nx, w_sdo_nx, w_busy_nx, w_tx_msb_nx;
    logic              w_lpbk, w_sample_bit;
    status_t           w_status;
    logic              w_unused_ba;

    assign w_hit      = bus_stb & (ba[13:12] == WIN_SEL) & ~sser;
    assign w_off      = ba[7:4];
    assign w_wr       = w_hit & ~br_w;
    assign w_wr_data  = w_wr & (w_off == OFF_DATA);
    assign w_wr_len   = w_wr & (w_off == OFF_LEN);
    assign w_wr_stat  = w_wr & (w_off == OFF_STATUS);
    assign w_active   = r_start | (r_state != ST_IDLE);
    assign w_acc_data = w_wr_data & ~w_active;
    assign w_unused_ba = ^{ba[11:8], ba[3:0]};

`ifdef SER_LOOPBACK_EN
    logic r_lpbk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lpbk <= 1'b0;
        end else if (w_wr & (w_off == OFF_CTRL)) begin
            r_lpbk <= bus_wdata[0];
        end
    end

    assign w_lpbk = r_lpbk;
`else
    assign w_lpbk = 1'b0;
`endif

    assign w_sample_bit = w_lpbk ? r_tx[DATA_W-1] : sdi;

    ser_phase_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .o_tick_c  (w_tick),
        .o_first_c (w_first)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus pin values for that state, registered alongside it
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_done_set   = 1'b0;
        w_abort_set  = 1'b0;
        w_scs_n_nx   = 1'b1;
        w_sclk_nx    = 1'b0;
        w_sdo_nx     = 1'b0;
        w_busy_nx    = 1'b0;
        w_tx_msb_nx  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_start) begin
                    if (sser) begin
                        w_abort_set = 1'b1;
                    end else begin
                        w_state_next = ST_SETUP;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_state_next = ST_LOW;
                    w_load       = 1'b1;
                end
            end
            ST_LOW: begin
                if (w_tick) begin
                    w_state_next = ST_HIGH;
                    w_load       = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_tick) begin
                    w_shift      = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = (r_bits <= LEN_W'(1)) ? ST_HOLD : ST_LOW;
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // sser high drops the window immediately, discarding the transfer
        if ((r_state != ST_IDLE) && sser) begin
            w_state_next = ST_IDLE;
            w_abort_set  = 1'b1;
            w_shift      = 1'b0;
            w_done_set   = 1'b0;
            w_load       = 1'b0;
        end

        w_tx_msb_nx = w_shift ? r_tx[DATA_W-2] : r_tx[DATA_W-1];

        case (w_state_next)
            ST_SETUP, ST_HOLD: begin
                w_scs_n_nx = 1'b0;
                w_busy_nx  = 1'b1;
            end
            ST_LOW: begin
                w_scs_n_nx = 1'b0;
                w_busy_nx  = 1'b1;
                w_sdo_nx   = w_tx_msb_nx & ~w_lpbk;
            end
            ST_HIGH: begin
                w_scs_n_nx = 1'b0;
                w_busy_nx  = 1'b1;
                w_sclk_nx  = 1'b1;
                w_sdo_nx   = w_tx_msb_nx & ~w_lpbk;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scs_n <= 1'b1;
            r_sclk  <= 1'b0;
            r_sdo   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_scs_n <= w_scs_n_nx;
            r_sclk  <= w_sclk_nx;
            r_sdo   <= w_sdo_nx;
            r_busy  <= w_busy_nx;
        end
    end

    // Shift datapath and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
            r_tx    <= '0;
            r_shift <= '0;
            r_rx    <= '0;
            r_bits  <= '0;
            r_len   <= LEN_MAX;
        end else begin
            r_start <= w_acc_data;
            if (w_acc_data) begin
                r_tx   <= bus_wdata;
                r_bits <= eff_len(r_len);
            end else if (w_shift) begin
                r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                r_bits <= r_bits - LEN_W'(1);
            end
            if (w_acc_data) begin
                r_shift <= '0;
            end else if ((r_state == ST_HIGH) && w_first) begin
                r_shift <= {r_shift[DATA_W-2:0], w_sample_bit};
            end
            if (w_done_set) begin
                r_rx <= r_shift;
            end
            if (w_wr_len & ~w_active) begin
                r_len <= bus_wdata[LEN_W-1:0];
            end
        end
    end

    // Sticky flags: a set in the same cycle as a CPU clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_done  <= w_done_set | (r_done & ~(w_wr_stat & bus_wdata[STAT_DONE]));
            r_ovr   <= ((w_wr_data | w_wr_len) & w_active)
                     | (r_ovr & ~(w_wr_stat & bus_wdata[STAT_OVR]));
            r_abort <= w_abort_set | (r_abort & ~(w_wr_stat & bus_wdata[STAT_ABORT]));
        end
    end

    always_comb begin
        w_status.abort   = r_abort;
        w_status.overrun = r_ovr;
        w_status.done    = r_done;
        w_status.busy    = r_busy;
    end

    always_comb begin
        bus_rdata = '0;
        if (w_hit & br_w) begin
            case (w_off)
                OFF_DATA:   bus_rdata = r_rx;
                OFF_STATUS: bus_rdata = DATA_W'(w_status);
                OFF_LEN:    bus_rdata = DATA_W'(r_len);
`ifdef SER_LOOPBACK_EN
                OFF_CTRL:   bus_rdata = DATA_W'(r_lpbk);
`endif
                default:    bus_rdata = '0;
            endcase
        end
    end

    assign scs_n    = r_scs_n;
    assign sclk     = r_sclk;
    assign sdo      = r_sdo;
    assign busy     = r_busy;
    assign done_irq = r_done;

endmodule

// File: doc/ser_window_seq.md
Name: ser_window_seq

Overview:
Bus-mapped serial transfer sequencer for the serial-select address window (ba[13]=0, ba[12]=1, sser=0).
- CPU loads a byte and length through registers decoded from ba[7:4].
- Block generates chip-select, serial clock and MSB-first data, samples the return line, then flags completion.
- Replaces discrete per-step address decoding with one self-timed engine and a busy/done handshake.

Parameters:
DATA_W, 8, shift register and bus data width
CLK_DIV, 4, system clocks per serial half-bit phase (legal range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
bus_stb  in  1  one-cycle strobe per bus access
ba  in  14  bus address
br_w  in  1  1=read, 0=write
sser  in  1  serial enable, active low; high aborts or blocks the window
bus_wdata  in  DATA_W  write data
bus_rdata  out  DATA_W  read data, valid the same cycle as bus_stb (combinational)
scs_n  out  1  serial chip select, active low
sclk  out  1  serial clock, idle low
sdo  out  1  serial data out
sdi  in  1  serial data in
busy  out  1  transfer in progress
done_irq  out  1  level; set on normal completion, cleared by the CPU

Behaviour:
- Register hit = bus_stb & ~ba[13] & ba[12] & ~sser. Offset = ba[7:4].
  - 0x0 DATA: write loads tx and starts a transfer; read returns last completed rx.
  - 0x1 STATUS: read {abort[3], overrun[2], done[1], busy[0]}; write with bit n set clears sticky bit n (n=1..3).
  - 0x2 LEN: bits[3:0] = bit count N; 0 or >8 means 8. Reads return LEN.
  - Other offsets: reads return 0, writes are ignored.
- Reset values: scs_n=1, sclk=0, sdo=0, busy=0, done_irq=0, all flags 0, LEN=8, tx=rx=0, FSM=IDLE.
- FSM states: IDLE, SETUP, LOW, HIGH, HOLD. Every state except IDLE lasts CLK_DIV cycles, timed by a phase counter.
  - IDLE -> SETUP on a DATA write. Next cycle: busy=1, scs_n=0.
  - SETUP -> LOW.
  - LOW: sclk=0, sdo=tx MSB.
  - HIGH: sclk=1. Sample sdi into rx LSB on the first HIGH cycle. On exit, shift tx left and decrement the bit count.
  - HIGH -> LOW while bits remain; otherwise HIGH -> HOLD.
  - HOLD -> IDLE: scs_n=1, busy=0, done=1 in the same cycle.
- Latency: busy falls and done rises exactly CLK_DIV*(2N+2)+1 cycles after the write edge (73 for CLK_DIV=4, N=8).
- For N<8, rx holds the received bits right-justified. tx uses its top N bits.
- DATA write while busy: ignored, overrun=1. LEN write while busy: ignored, overrun=1.
- sser rising while busy: abort next cycle. Return to IDLE, scs_n=1, sclk=0, abort=1, done unchanged, rx unchanged.
- Done set and CPU clear in the same cycle: set wins.
- Async reset mid-transfer: all outputs return to reset values immediately.
- done_irq = done flag.

Optional Feature:
SER_LOOPBACK_EN
- Defined: adds CTRL register 0x3 bit0 `lpbk` (reset 0). When set, the sampled bit is sdo instead of sdi, and the sdo pin is held 0.
- Not defined: offset 0x3 reads 0, writes are ignored, sampling always uses sdi.

Decomposition:
- Package ser_seq_pkg: state enum, register offset constants, STATUS bit indices, window decode constants (ba[13:12]=2'b01).
- Sub-module ser_phase_tick: loadable down-counter of CLK_DIV width that emits a phase-end pulse. Instantiated once.

Test Plan:
- Reset, then LEN=8, write DATA=0xA5 with sdi tied to the inverse of sdo -> sdo sequence 1,0,1,0,0,1,0,1; DATA read = 0x5A; done at cycle 73; busy=0.
- LEN=3, DATA=0xE0, sdi=1 -> 3 sclk pulses; rx=0x07; done at cycle 4*8+1=33.
- DATA write at cycle 10 of an active transfer -> STATUS=0x05 (overrun, busy); the original transfer completes unchanged.
- sser=1 during the 4th HIGH phase -> scs_n=1 next cycle; STATUS=0x08; done_irq=0.
- STATUS write 0x02 on the exact done-set cycle -> done stays 1. A later write of 0x02 -> done_irq=0.
- SER_LOOPBACK_EN defined, lpbk=1, DATA=0x3C -> rx=0x3C, sdo pin constantly 0.
